// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback port arbiter.
package wb_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefDepth     = 2;
    localparam int unsigned DefMaxWait   = 4;

    // One pending register-file write at the default widths.
    typedef struct packed {
        logic [DefAddrWidth-1:0] rd;
        logic [DefDataWidth-1:0] data;
    } wb_req_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        GntNone,
        GntPipe,
        GntDrain,
        GntForce
    } grant_e;

endpackage

// File: rtl/ll_fifo.sv
// Ring buffer holding long-latency results until the write port is free.
module ll_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37,
    parameter int unsigned CntW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a
// long-latency unit, buffering the latter and forcing drains when needed.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned MAX_WAIT   = DefMaxWait
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_w,
    input  logic [ADDR_WIDTH-1:0] rd_w,
    input  logic [DATA_WIDTH-1:0] result_w,
    input  logic                  ll_valid,
    input  logic [ADDR_WIDTH-1:0] ll_rd,
    input  logic [DATA_WIDTH-1:0] ll_data,
    output logic                  ll_ready,
    output logic                  stall_wb,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam int unsigned ReqW  = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [CntW-1:0]  FullCnt   = CntW'(DEPTH);
    localparam logic [WaitW-1:0] WaitLimit = WaitW'(MAX_WAIT);

    logic [CntW-1:0]       count;
    logic [ReqW-1:0]       head;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    logic pipe_req, full, not_empty, force_drain, push, pop;
    grant_e grant;

    logic [WaitW-1:0]      wait_q, wait_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    ll_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ReqW),
        .CntW  (CntW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({ll_rd, ll_data}),
        .head_o  (head),
        .count_o (count)
    );

    assign head_rd   = head[ReqW-1:DATA_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // x0 writes are dropped at both sources so rf_we never targets x0.
    assign pipe_req    = reg_write_w && (rd_w != '0);
    assign full        = (count == FullCnt);
    assign not_empty   = (count != '0);
    // Registered state only: keeps stall_wb off any input-to-output path.
    assign force_drain = full || (not_empty && (wait_q >= WaitLimit));

    assign ll_ready = !rst && !full;
    assign stall_wb = !rst && force_drain;
    assign push     = ll_valid && ll_ready && (ll_rd != '0);
    assign pop      = (grant == GntForce) || (grant == GntDrain);

    // Grant priority: forced drain, then pipeline, then opportunistic drain.
    always_comb begin
        grant = GntNone;
        if (force_drain)    grant = GntForce;
        else if (pipe_req)  grant = GntPipe;
        else if (not_empty) grant = GntDrain;
    end

    // Next write-port contents; address/data hold when nothing is granted.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        unique case (grant)
            GntForce, GntDrain: begin
                rf_we_d    = 1'b1;
                rf_addr_d  = head_rd;
                rf_wdata_d = head_data;
            end
            GntPipe: begin
                rf_we_d    = 1'b1;
                rf_addr_d  = rd_w;
                rf_wdata_d = result_w;
            end
            GntNone: ;
            default: ;
        endcase
    end

    // Age of the current head: restarts on every pop, saturates at the limit.
    always_comb begin
        wait_d = wait_q;
        if (pop || !not_empty) begin
            wait_d = '0;
        end else if (wait_q < WaitLimit) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Wait counter and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_q     <= wait_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: every rf write is checked in order
// against a queue of expected writes filled as stimulus is applied.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic        stall_wb;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    wb_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .DEPTH      (2),
        .MAX_WAIT   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_write_w (reg_write_w),
        .rd_w        (rd_w),
        .result_w    (result_w),
        .ll_valid    (ll_valid),
        .ll_rd       (ll_rd),
        .ll_data     (ll_data),
        .ll_ready    (ll_ready),
        .stall_wb    (stall_wb),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    // Advance one clock, then compare any write the DUT issued against the queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rf_we === 1'b1) begin
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rf_addr), 64'(e.a));
                chk("wr_data", 64'(rf_wdata), 64'(e.d));
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        reg_write_w = 1'b0;
        rd_w        = '0;
        result_w    = '0;
        ll_valid    = 1'b1;
        ll_rd       = 5'd9;
        ll_data     = 32'h9999;

        // Reset held three cycles with a long-latency offer present.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ll_ready", 64'(ll_ready), 64'd0);
            chk("rst_rf_we", 64'(rf_we), 64'd0);
            chk("rst_rf_addr", 64'(rf_addr), 64'd0);
            chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
            chk("rst_stall", 64'(stall_wb), 64'd0);
        end
        rst      = 1'b0;
        ll_valid = 1'b0;
        #1;
        chk("post_rst_ll_ready", 64'(ll_ready), 64'd1);
        tick();
        chk("idle_rf_we", 64'(rf_we), 64'd0);

        // Pipeline-only writes; x0 is suppressed.
        reg_write_w = 1'b1;
        rd_w        = 5'd5;
        result_w    = 32'hDEADBEEF;
        exp_wr(5'd5, 32'hDEADBEEF);
        tick();
        chk("pipe_we", 64'(rf_we), 64'd1);
        rd_w     = 5'd0;
        result_w = 32'h1111;
        tick();
        chk("pipe_x0_we", 64'(rf_we), 64'd0);
        reg_write_w = 1'b0;

        // Idle-pipeline drain of a single entry; no same-cycle bypass.
        ll_valid = 1'b1;
        ll_rd    = 5'd7;
        ll_data  = 32'h1234;
        exp_wr(5'd7, 32'h1234);
        tick();
        ll_valid = 1'b0;
        chk("drain_no_bypass", 64'(rf_we), 64'd0);
        tick();
        chk("drain_we", 64'(rf_we), 64'd1);
        chk("drain_stall", 64'(stall_wb), 64'd0);
        tick();
        chk("drain_empty_we", 64'(rf_we), 64'd0);

        // x0 long-latency result is accepted but never written.
        ll_valid = 1'b1;
        ll_rd    = 5'd0;
        ll_data  = 32'h5555;
        tick();
        ll_valid = 1'b0;
        tick();
        chk("ll_x0_we", 64'(rf_we), 64'd0);

        // Fill the buffer while the pipeline writes every cycle.
        reg_write_w = 1'b1;
        rd_w        = 5'd10;
        result_w    = 32'h100;
        ll_valid    = 1'b1;
        ll_rd       = 5'd3;
        ll_data     = 32'hA;
        exp_wr(5'd10, 32'h100);
        tick();
        chk("fill1_ready", 64'(ll_ready), 64'd1);
        ll_rd   = 5'd4;
        ll_data = 32'hB;
        exp_wr(5'd10, 32'h100);
        tick();
        ll_valid = 1'b0;
        chk("full_ready", 64'(ll_ready), 64'd0);
        chk("full_stall", 64'(stall_wb), 64'd1);
        rd_w     = 5'd11;
        result_w = 32'h200;
        exp_wr(5'd3, 32'hA);
        tick();
        chk("full_force_we", 64'(rf_we), 64'd1);
        chk("full_stall_drop", 64'(stall_wb), 64'd0);
        chk("full_ready_back", 64'(ll_ready), 64'd1);
        exp_wr(5'd11, 32'h200);
        tick();
        chk("held_pipe_we", 64'(rf_we), 64'd1);
        reg_write_w = 1'b0;
        exp_wr(5'd4, 32'hB);
        tick();
        chk("second_entry_we", 64'(rf_we), 64'd1);
        tick();
        chk("full_done_we", 64'(rf_we), 64'd0);

        // Starvation: the head ages out while the pipeline keeps the port busy.
        reg_write_w = 1'b1;
        rd_w        = 5'd12;
        result_w    = 32'h300;
        ll_valid    = 1'b1;
        ll_rd       = 5'd6;
        ll_data     = 32'h66;
        exp_wr(5'd12, 32'h300);
        tick();
        ll_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("starve_no_stall", 64'(stall_wb), 64'd0);
            exp_wr(5'd12, 32'h300);
            tick();
        end
        chk("starve_stall", 64'(stall_wb), 64'd1);
        exp_wr(5'd6, 32'h66);
        tick();
        chk("starve_force_we", 64'(rf_we), 64'd1);
        chk("starve_stall_drop", 64'(stall_wb), 64'd0);
        rd_w     = 5'd13;
        result_w = 32'h400;
        exp_wr(5'd13, 32'h400);
        tick();
        chk("starve_resume_we", 64'(rf_we), 64'd1);
        reg_write_w = 1'b0;
        tick();
        chk("starve_done_we", 64'(rf_we), 64'd0);

        // Push and pop together at count=1, then reset with an entry buffered.
        ll_valid = 1'b1;
        ll_rd    = 5'd8;
        ll_data  = 32'h88;
        exp_wr(5'd8, 32'h88);
        tick();
        ll_rd   = 5'd9;
        ll_data = 32'h99;
        exp_wr(5'd9, 32'h99);
        tick();
        chk("pp1_we", 64'(rf_we), 64'd1);
        chk("pp1_ready", 64'(ll_ready), 64'd1);
        ll_rd   = 5'd14;
        ll_data = 32'hEE;
        tick();
        chk("pp2_we", 64'(rf_we), 64'd1);
        chk("pp2_ready", 64'(ll_ready), 64'd1);
        ll_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_addr", 64'(rf_addr), 64'd0);
        chk("mid_rst_stall", 64'(stall_wb), 64'd0);
        rst = 1'b0;
        tick();
        chk("after_rst_we", 64'(rf_we), 64'd0);
        chk("after_rst_stall", 64'(stall_wb), 64'd0);
        chk("after_rst_ready", 64'(ll_ready), 64'd1);
        tick();
        chk("after_rst_we2", 64'(rf_we), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
